jt10_adpcmb_fetch: RTL and testbench
====================================

# jt10_adpcmb_fetch

ADPCM-B sample fetcher for the YM2610 core. It walks the sample ROM from the start address to the end address at a rate set by the 16-bit delta-N value. It prefetches one byte ahead and presents one 4-bit ADPCM code at a time, high nibble first. It sits directly upstream of the ADPCM-B delta-T decoder, driving that decoder's `data` and `chon` inputs and advancing it with `adv`.

## Interface
Parameters:
- `ADDRW`, 24: ROM byte-address width.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `cen`  in  1  clock enable; all state advances only on `cen`-qualified edges
- `play`  in  1  level; rising edge starts playback, low stops it
- `repeat_en`  in  1  loop back to start at end of sample
- `start_addr`  in  16  start, in 256-byte units
- `end_addr`  in  16  end, in 256-byte units, inclusive
- `delta_n`  in  16  rate increment; the nibble rate is `cen` rate × delta_n / 65536
- `flag_clr`  in  1  clears `eos`
- `rom_addr`  out  ADDRW  byte address
- `rom_cs`  out  1  read request
- `rom_data`  in  8  ROM byte
- `rom_ok`  in  1  `rom_data` valid for the current `rom_addr`
- `data`  out  4  current ADPCM code
- `chon`  out  1  channel on
- `adv`  out  1  one-`cen` pulse: a new code is on `data`
- `eos`  out  1  sticky end-of-sample flag
- `underrun`  out  1  sticky; set when a code was due but no byte was ready

## Operation
- Address registers:
  - `start_addr` and `end_addr` widen to byte addresses `{start_addr,8'h00}` and `{end_addr,8'hFF}`.
  - The upper ADDRW−24 bits are zero.
- State machine states: IDLE, PRIME, PLAY.
- IDLE:
  - `chon`=0, `rom_cs`=0, `data`=0.
  - A `play` 0→1 edge, sampled on `cen`, does the following:
    - Sets fetch address = start.
    - Sets acc=0, nib=0, cur_valid=0, nxt_valid=0.
    - Moves to PRIME.
- Fetch engine (PRIME and PLAY):
  - Whenever a buffer slot is free, drive `rom_cs`=1 with `rom_addr`=fetch address.
  - Accept `rom_data` on a `cen` edge where `rom_ok`=1. `rom_ok` is ignored on the first `cen` after `rom_addr` changes.
  - On accept: fill cur if it is empty, else fill nxt.
  - After accept: if fetch address == end, then wrap to start if `repeat_en` is set, else stop fetching. Otherwise increment the fetch address.
  - `rom_cs` drops on the accept cycle.
- PRIME:
  - When cur is valid, move to PLAY.
  - Also present `data`=cur[7:4] and pulse `adv`.
- PLAY:
  - `chon`=1.
  - Each `cen`: {carry,acc} = acc + delta_n, 17-bit; acc keeps the low 16 bits.
  - On carry with nib=0: set nib=1, `data`=cur[3:0], pulse `adv`.
  - On carry with nib=1, the byte is finished:
    - If that byte was the end byte and `repeat_en`=0: set `eos`, go to IDLE, `chon`=0.
    - If that byte was the end byte and `repeat_en`=1: set `eos` and continue.
    - When continuing: if nxt is valid, set cur←nxt, nxt_valid=0, nib=0, `data`=new cur[7:4], pulse `adv`.
    - If nxt is not valid: set `underrun`, hold `data`, stay at nib=1, and retry on the next carry.
- `play` low in any state → IDLE on the next `cen`. Any outstanding fetch is abandoned; `eos` is not set.
- `play` rising again while in PLAY restarts from start, the same as from IDLE.
- `flag_clr` clears `eos` and `underrun`. A set and a clear on the same edge: set wins.
- `delta_n`=0: `chon`=1 and `data` is frozen; no `adv`.
- `delta_n`=FFFF: a carry on nearly every `cen`. Prefetch must sustain one byte per 2 `cen` when `rom_ok` returns within 1 `cen` of being sampled.

## Timing
- Reset values:
  - `rom_addr`=0, `rom_cs`=0, `data`=0, `chon`=0, `adv`=0, `eos`=0, `underrun`=0.
  - State IDLE, acc=0.
- All outputs are registered.
- `adv` is exactly one `cen`-qualified cycle wide and coincides with the first cycle of new `data`.
- First-code latency: a `play` edge at `cen` n with `rom_ok` held high gives:
  - `rom_cs` at n+1;
  - accept at n+2;
  - PRIME→PLAY with the first `adv` at n+3.
- `rst_n` assertion forces the reset values immediately, regardless of `cen`.

## Test plan
- start=0x0010, end=0x0010, delta_n=0x8000, ROM byte k = k[7:0], `rom_ok`=1:
  - `adv` every 2 `cen`;
  - codes 0,0,0,1,0,2,… up to F,F at address 0x0010FF;
  - then `eos`=1, `chon`=0, state IDLE.
- Same setup with `repeat_en`=1: after 0x0010FF, `rom_addr` returns to 0x001000; `eos`=1 while `chon` stays 1.
- delta_n=0xFFFF with `rom_ok` delayed 6 `cen` per read:
  - `underrun` goes to 1;
  - no code is skipped or duplicated except the hold of the stalled code.
- delta_n=0x0000 after the first code: `data` is stable and there is no `adv` for 1000 `cen`.
- `play` dropped in mid-sample:
  - `chon`=0 within 1 `cen`, `rom_cs`=0, `eos` stays 0;
  - the next `play` rise restarts from the start address.
- `rst_n` pulsed low during a ROM wait: all outputs go to their reset values asynchronously; a later play runs correctly.

Source files
------------

// File: rtl/jt10_adpcmb_fetch.sv
// ADPCM-B sample fetcher: walks ROM start..end through a 2-byte buffer, emitting nibbles high-first at delta_n/65536 per cen.
// First code 3 cen after play rises; a late ROM holds the current code and raises underrun.
module jt10_adpcmb_fetch #(
   parameter int ADDRW = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cen,
   input  logic             play,
   input  logic             repeat_en,
   input  logic [15:0]      start_addr,
   input  logic [15:0]      end_addr,
   input  logic [15:0]      delta_n,
   input  logic             flag_clr,
   output logic [ADDRW-1:0] rom_addr,
   output logic             rom_cs,
   input  logic [7:0]       rom_data,
   input  logic             rom_ok,
   output logic [3:0]       data,
   output logic             chon,
   output logic             adv,
   output logic             eos,
   output logic             underrun
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PRIME = 2'd1;
   localparam logic [1:0] PLAY  = 2'd2;

   logic [1:0]       st;
   logic             play_d;
   logic             fetching;
   logic [7:0]       cur;
   logic [7:0]       nxt;
   logic             cur_valid;
   logic             nxt_valid;
   logic             cur_end;
   logic             nxt_end;
   logic             nib;
   logic [15:0]      acc;
   logic [16:0]      sum;
   logic [ADDRW-1:0] start_byte;
   logic [ADDRW-1:0] end_byte;
   logic             play_rise;
   logic             in_fetch;
   logic             carry;
   logic             at_end;
   logic             done;
   logic             consume;
   logic             accept;
   logic             cur_valid_n;
   logic             nxt_valid_n;
   logic             fetching_n;

   assign start_byte = ADDRW'({start_addr, 8'h00});
   assign end_byte   = ADDRW'({end_addr, 8'hFF});
   assign play_rise  = play & ~play_d;
   assign in_fetch   = (st == PRIME) || (st == PLAY);
   assign sum        = {1'b0, acc} + {1'b0, delta_n};
   assign carry      = sum[16];
   assign at_end     = (rom_addr == end_byte);
   assign done       = (st == PLAY) & carry & nib & cur_end & ~repeat_en;
   assign consume    = (st == PLAY) & carry & nib & ~done & nxt_valid;
   // rom_cs is only raised one cen after rom_addr settles, so a registered
   // rom_cs already skips the first rom_ok after an address change.
   assign accept     = in_fetch & play & ~play_rise & ~done & rom_cs & rom_ok;
   assign cur_valid_n = cur_valid | accept;
   assign nxt_valid_n = (nxt_valid & ~consume) | (accept & cur_valid);
   assign fetching_n  = fetching & ~(accept & at_end & ~repeat_en);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= IDLE;
         play_d    <= 1'b0;
         fetching  <= 1'b0;
         cur       <= 8'h00;
         nxt       <= 8'h00;
         cur_valid <= 1'b0;
         nxt_valid <= 1'b0;
         cur_end   <= 1'b0;
         nxt_end   <= 1'b0;
         nib       <= 1'b0;
         acc       <= 16'h0000;
         rom_addr  <= '0;
         rom_cs    <= 1'b0;
         data      <= 4'h0;
         chon      <= 1'b0;
         adv       <= 1'b0;
         eos       <= 1'b0;
         underrun  <= 1'b0;
      end else if (cen) begin
         play_d   <= play;
         adv      <= 1'b0;
         eos      <= eos & ~flag_clr;
         underrun <= underrun & ~flag_clr;
         if (!play) begin
            st     <= IDLE;
            chon   <= 1'b0;
            rom_cs <= 1'b0;
            data   <= 4'h0;
         end else if (play_rise) begin
            st        <= PRIME;
            rom_addr  <= start_byte;
            rom_cs    <= 1'b0;
            fetching  <= 1'b1;
            acc       <= 16'h0000;
            nib       <= 1'b0;
            cur_valid <= 1'b0;
            nxt_valid <= 1'b0;
            chon      <= 1'b0;
            data      <= 4'h0;
         end else begin
            if (st == PRIME && cur_valid) begin
               st   <= PLAY;
               chon <= 1'b1;
               data <= cur[7:4];
               adv  <= 1'b1;
            end
            if (st == PLAY) begin
               acc <= sum[15:0];
               if (carry && !nib) begin
                  nib  <= 1'b1;
                  data <= cur[3:0];
                  adv  <= 1'b1;
               end
               if (carry && nib && cur_end) eos <= 1'b1;
               if (done) begin
                  st   <= IDLE;
                  chon <= 1'b0;
                  data <= 4'h0;
               end
               if (consume) begin
                  cur     <= nxt;
                  cur_end <= nxt_end;
                  nib     <= 1'b0;
                  data    <= nxt[7:4];
                  adv     <= 1'b1;
               end
               // Stalled byte: keep nib=1 so the next carry retries the swap.
               if (carry && nib && !done && !nxt_valid) underrun <= 1'b1;
            end
            if (accept) begin
               if (!cur_valid) begin
                  cur     <= rom_data;
                  cur_end <= at_end;
               end else begin
                  nxt     <= rom_data;
                  nxt_end <= at_end;
               end
               if (!at_end)        rom_addr <= rom_addr + ADDRW'(1);
               else if (repeat_en) rom_addr <= start_byte;
            end
            cur_valid <= cur_valid_n;
            nxt_valid <= nxt_valid_n;
            fetching  <= fetching_n;
            rom_cs    <= in_fetch & ~done & fetching_n & ~accept & ~(cur_valid_n & nxt_valid_n);
         end
      end
   end

endmodule

// File: tb/tb_jt10_adpcmb_fetch.sv
// Directed bench for jt10_adpcmb_fetch: ROM byte at offset k reads k ^ rom_xor, with optional read latency.
module tb_jt10_adpcmb_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cen = 1'b0;
   logic        play = 1'b0;
   logic        repeat_en = 1'b0;
   logic [15:0] start_addr = 16'h0010;
   logic [15:0] end_addr = 16'h0010;
   logic [15:0] delta_n = 16'h8000;
   logic        flag_clr = 1'b0;
   logic [23:0] rom_addr;
   logic        rom_cs;
   logic [7:0]  rom_data;
   logic        rom_ok = 1'b1;
   logic [3:0]  data;
   logic        chon;
   logic        adv;
   logic        eos;
   logic        underrun;

   int          n_vec = 0;
   int          n_bad = 0;
   int          cen_cnt = 0;
   int          code_idx = 0;
   int          last_adv = 0;
   int          lat = 0;
   int          wcnt = 0;
   bit          gap_chk = 1'b0;
   bit          seen_end = 1'b0;
   bit          wrapped = 1'b0;
   logic [7:0]  rom_xor = 8'h00;

   jt10_adpcmb_fetch #(.ADDRW(24)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .play(play), .repeat_en(repeat_en),
      .start_addr(start_addr), .end_addr(end_addr), .delta_n(delta_n), .flag_clr(flag_clr),
      .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
      .data(data), .chon(chon), .adv(adv), .eos(eos), .underrun(underrun)
   );

   initial forever #5 clk = ~clk;
   always @(negedge clk) cen = ~cen;

   assign rom_data = rom_addr[7:0] ^ rom_xor;

   // rom_ok rises once rom_cs has been seen high on lat cen edges
   always @(posedge clk) begin
      #2;
      if (cen) begin
         if (rom_cs) wcnt = wcnt + 1;
         else        wcnt = 0;
      end
      rom_ok = (lat == 0) || (rom_cs && wcnt >= lat);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cen %0d)", tag, got, exp, cen_cnt);
      end
   endtask

   function automatic logic [3:0] exp_code(input int idx);
      logic [7:0] b;
      b = 8'(idx / 2) ^ rom_xor;
      return (idx % 2 == 0) ? b[7:4] : b[3:0];
   endfunction

   task automatic step();
      @(posedge clk);
      while (!cen) @(posedge clk);
      #1;
      cen_cnt++;
   endtask

   task automatic pulse_clr();
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
   endtask

   task automatic start_play();
      play = 1'b1;
      code_idx = 0;
      step();
      check("n0_cs", rom_cs, 0);
      check("n0_chon", chon, 0);
      step();
      check("n1_cs", rom_cs, 1);
      check("n1_addr", rom_addr, 24'h001000);
      step();
      check("n2_cs", rom_cs, 0);
      check("n2_adv", adv, 0);
      step();
      check("n3_adv", adv, 1);
      check("n3_chon", chon, 1);
      check("first_code", data, exp_code(0));
      code_idx = 1;
      last_adv = cen_cnt;
   endtask

   task automatic watch(input int max_cen, input bit until_eos);
      for (int i = 0; i < max_cen; i++) begin
         step();
         if (adv) begin
            check("code", data, exp_code(code_idx));
            if (gap_chk) check("adv_gap", cen_cnt - last_adv, 2);
            last_adv = cen_cnt;
            code_idx++;
         end
         if (rom_addr == 24'h0010FF) seen_end = 1'b1;
         else if (seen_end && rom_addr == 24'h001000) wrapped = 1'b1;
         if (until_eos && eos) break;
      end
   endtask

   initial begin
      int nadv;
      int nchg;
      logic [3:0] d0;

      // reset values
      step();
      step();
      check("rst_addr", rom_addr, 0);
      check("rst_cs", rom_cs, 0);
      check("rst_data", data, 0);
      check("rst_chon", chon, 0);
      check("rst_adv", adv, 0);
      check("rst_eos", eos, 0);
      check("rst_urun", underrun, 0);
      rst_n = 1'b1;
      step();
      step();

      // single page, no repeat: 512 codes, then eos and idle
      gap_chk = 1'b1;
      start_play();
      watch(1200, 1'b1);
      check("t1_ncodes", code_idx, 512);
      check("t1_eos", eos, 1);
      check("t1_chon", chon, 0);
      check("t1_data", data, 0);
      check("t1_cs", rom_cs, 0);
      check("t1_urun", underrun, 0);
      step();
      check("t1_idle_adv", adv, 0);
      pulse_clr();
      check("t1_eos_clr", eos, 0);

      // repeat: wraps to 0x001000, eos while chon stays up
      play = 1'b0;
      repeat_en = 1'b1;
      seen_end = 1'b0;
      wrapped = 1'b0;
      step();
      start_play();
      watch(1300, 1'b1);
      check("t2_eos", eos, 1);
      check("t2_chon", chon, 1);
      check("t2_ncodes", code_idx, 513);
      check("t2_wrapped", wrapped, 1);
      watch(40, 1'b0);
      check("t2_chon_after", chon, 1);
      check("t2_urun", underrun, 0);

      // fast rate with slow ROM: underrun, codes strictly in order
      play = 1'b0;
      repeat_en = 1'b0;
      step();
      pulse_clr();
      delta_n = 16'hFFFF;
      lat = 6;
      gap_chk = 1'b0;
      step();
      play = 1'b1;
      code_idx = 0;
      watch(400, 1'b0);
      check("t3_urun", underrun, 1);
      check("t3_progress", code_idx >= 40, 1);
      check("t3_eos", eos, 0);

      // delta_n = 0: first code then frozen
      play = 1'b0;
      lat = 0;
      step();
      pulse_clr();
      check("t4_urun_clr", underrun, 0);
      delta_n = 16'h0000;
      rom_xor = 8'hA5;
      step();
      start_play();
      nadv = 0;
      nchg = 0;
      d0 = data;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (adv) nadv++;
         if (data !== d0) nchg++;
      end
      check("t4_adv", nadv, 0);
      check("t4_chg", nchg, 0);
      check("t4_data", data, 4'hA);
      check("t4_chon", chon, 1);
      check("t4_cs", rom_cs, 0);

      // play dropped mid-sample, then restart from start
      play = 1'b0;
      step();
      delta_n = 16'h8000;
      rom_xor = 8'h00;
      gap_chk = 1'b1;
      step();
      start_play();
      watch(40, 1'b0);
      play = 1'b0;
      step();
      check("t5_chon", chon, 0);
      check("t5_cs", rom_cs, 0);
      check("t5_eos", eos, 0);
      check("t5_data", data, 0);
      step();
      start_play();
      watch(30, 1'b0);
      check("t5_codes", code_idx >= 14, 1);

      // async reset during a ROM wait
      play = 1'b0;
      lat = 6;
      step();
      step();
      play = 1'b1;
      step();
      step();
      step();
      check("t6_waiting", rom_cs, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_addr", rom_addr, 0);
      check("t6_cs", rom_cs, 0);
      check("t6_data", data, 0);
      check("t6_chon", chon, 0);
      check("t6_adv", adv, 0);
      check("t6_eos", eos, 0);
      check("t6_urun", underrun, 0);
      play = 1'b0;
      lat = 0;
      step();
      step();
      rst_n = 1'b1;
      step();
      step();
      start_play();
      watch(30, 1'b0);
      check("t6_codes", code_idx >= 14, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
